i2c_registers: RTL and testbench

//   Register file holding the three PID gains (K_p, K_i, K_d) written and read over the I2C slave.
//   The I2C front end decodes a register address plus a read/write strobe and hands them to this block.
//   The block drives the gains continuously to the PID datapath.

---
 rtl/pid_regs_pkg.sv | 30 +++
 rtl/gain_reg.sv | 34 +++
 rtl/i2c_registers.sv | 96 +++++++++
 tb/tb_i2c_registers.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pid_regs_pkg.sv
// Shared definitions for the PID gain register map: widths, addresses and the
// address decode used by the register file, the I2C slave and the bench.
package pid_regs_pkg;

    localparam int DATA_W = 6;
    localparam int ADDR_W = 8;

    localparam logic [ADDR_W-1:0] K_P_ADDR = 8'h20;
    localparam logic [ADDR_W-1:0] K_I_ADDR = 8'h21;
    localparam logic [ADDR_W-1:0] K_D_ADDR = 8'h22;

    typedef logic [DATA_W-1:0] gain_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic kp;
        logic ki;
        logic kd;
    } gain_sel_t;

    // One-hot select; all zero for an unmapped address.
    function automatic gain_sel_t decode_addr(input addr_t addr);
        gain_sel_t sel;
        sel.kp = (addr == K_P_ADDR);
        sel.ki = (addr == K_I_ADDR);
        sel.kd = (addr == K_D_ADDR);
        return sel;
    endfunction

endpackage

// File: rtl/gain_reg.sv
// Single gain register with synchronous active-low reset and a load enable.
module gain_reg
    import pid_regs_pkg::*;
#(
    parameter gain_t RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    gain_t val_q;
    gain_t val_d;

    always_comb begin
        val_d = val_q;
        if (load_en) begin
            val_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/i2c_registers.sv
// PID gain register file behind the I2C slave: address-decoded writes, a
// registered read port, and the three gains driven straight from their flops.
module i2c_registers
    import pid_regs_pkg::*;
#(
    parameter gain_t K_P_RST = '0,
    parameter gain_t K_I_RST = '0,
    parameter gain_t K_D_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] update_value,
    input  logic              read_or_write,
    output logic [DATA_W-1:0] read_value,
    output logic [DATA_W-1:0] K_p,
    output logic [DATA_W-1:0] K_i,
    output logic [DATA_W-1:0] K_d
);

    gain_sel_t sel;
    logic      wr_en;
    logic      rd_en;
    logic      ld_kp;
    logic      ld_ki;
    logic      ld_kd;
    gain_t     k_p_q;
    gain_t     k_i_q;
    gain_t     k_d_q;
    gain_t     read_value_q;
    gain_t     read_value_d;

    // ena gates both strobes first, so an undriven address cannot reach state.
    always_comb begin
        wr_en = ena & read_or_write;
        rd_en = ena & ~read_or_write;
        sel   = decode_addr(reg_addr);
        ld_kp = wr_en & sel.kp;
        ld_ki = wr_en & sel.ki;
        ld_kd = wr_en & sel.kd;
    end

    always_comb begin
        read_value_d = read_value_q;
        if (rd_en) begin
            if (sel.kp) begin
                read_value_d = k_p_q;
            end else if (sel.ki) begin
                read_value_d = k_i_q;
            end else if (sel.kd) begin
                read_value_d = k_d_q;
            end else begin
                read_value_d = '0;
            end
        end
    end

    gain_reg #(.RST_VAL(K_P_RST)) u_kp (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (ld_kp),
        .d       (update_value),
        .q       (k_p_q)
    );

    gain_reg #(.RST_VAL(K_I_RST)) u_ki (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (ld_ki),
        .d       (update_value),
        .q       (k_i_q)
    );

    gain_reg #(.RST_VAL(K_D_RST)) u_kd (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (ld_kd),
        .d       (update_value),
        .q       (k_d_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_value_q <= '0;
        end else begin
            read_value_q <= read_value_d;
        end
    end

    assign read_value = read_value_q;
    assign K_p        = k_p_q;
    assign K_i        = k_i_q;
    assign K_d        = k_d_q;

endmodule

// File: tb/tb_i2c_registers.sv
// Bench for the PID gain register file: directed vector table, hand-written
// corner sequences and a random phase against a behavioural model.
module tb_i2c_registers;
    import pid_regs_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] update_value;
    logic              read_or_write;
    logic [DATA_W-1:0] read_value;
    logic [DATA_W-1:0] K_p;
    logic [DATA_W-1:0] K_i;
    logic [DATA_W-1:0] K_d;

    int checks;
    int errors;

    typedef struct {
        logic        rst_n;
        logic        ena;
        logic        rw;
        logic [7:0]  addr;
        logic [5:0]  data;
        int          hold;
        logic [5:0]  exp_kp;
        logic [5:0]  exp_ki;
        logic [5:0]  exp_kd;
        logic [5:0]  exp_rv;
    } vec_t;

    typedef struct {
        string       name;
        logic [5:0]  kp;
        logic [5:0]  ki;
        logic [5:0]  kd;
        logic [5:0]  rv;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];

    logic [5:0] m_kp, m_ki, m_kd, m_rv;

    i2c_registers dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .reg_addr      (reg_addr),
        .update_value  (update_value),
        .read_or_write (read_or_write),
        .read_value    (read_value),
        .K_p           (K_p),
        .K_i           (K_i),
        .K_d           (K_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic rw,
                         input logic [7:0] a, input logic [5:0] d);
        rst_n         = r;
        ena           = e;
        read_or_write = rw;
        reg_addr      = a;
        update_value  = d;
    endtask

    // One edge, then compare the oldest scoreboard entry away from the edge.
    task automatic step_and_check();
        exp_t x;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got 0 expected 1");
        end else begin
            x = sb.pop_front();
            check({x.name, "_kp"}, K_p, x.kp);
            check({x.name, "_ki"}, K_i, x.ki);
            check({x.name, "_kd"}, K_d, x.kd);
            check({x.name, "_rv"}, read_value, x.rv);
        end
    endtask

    task automatic push(input string n, input logic [5:0] kp, input logic [5:0] ki,
                        input logic [5:0] kd, input logic [5:0] rv);
        exp_t x;
        x.name = n; x.kp = kp; x.ki = ki; x.kd = kd; x.rv = rv;
        sb.push_back(x);
    endtask

    // Independent reference: applies one transaction to the model state.
    task automatic model_step(input logic r, input logic e, input logic rw,
                              input logic [7:0] a, input logic [5:0] d);
        if (!r) begin
            m_kp = 0; m_ki = 0; m_kd = 0; m_rv = 0;
        end else if (e) begin
            if (rw) begin
                if (a == 8'h20) m_kp = d;
                else if (a == 8'h21) m_ki = d;
                else if (a == 8'h22) m_kd = d;
            end else begin
                case (a)
                    8'h20:   m_rv = m_kp;
                    8'h21:   m_rv = m_ki;
                    8'h22:   m_rv = m_kd;
                    default: m_rv = 0;
                endcase
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 6'd0);

        //        rst   ena   rw    addr   data hold  kp  ki  kd  rv
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 6'd0,  2,  0,  0,  0,  0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h20, 6'd8,  5,  8,  0,  0,  0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'h21, 6'd16, 5,  8, 16,  0,  0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h22, 6'd32, 5,  8, 16, 32,  0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h20, 6'd0,  1,  8, 16, 32,  8};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h21, 6'd0,  1,  8, 16, 32, 16};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h22, 6'd0,  1,  8, 16, 32, 32};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h20, 6'd63, 2,  8, 16, 32, 32};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h23, 6'd5,  1,  8, 16, 32, 32};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h23, 6'd0,  1,  8, 16, 32,  0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h21, 6'd63, 1,  8, 63, 32,  0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h21, 6'd0,  1,  8,  0, 32,  0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h22, 6'd7,  1,  8,  0,  7,  0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h22, 6'd0,  1,  8,  0,  7,  7};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'hFF, 6'd21, 2,  8,  0,  7,  7};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h20, 6'd12, 1,  0,  0,  0,  0};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            for (int h = 0; h < vecs[i].hold; h++) begin
                drive(vecs[i].rst_n, vecs[i].ena, vecs[i].rw, vecs[i].addr, vecs[i].data);
                push($sformatf("vec%0d_c%0d", i, h),
                     vecs[i].exp_kp, vecs[i].exp_ki, vecs[i].exp_kd, vecs[i].exp_rv);
                step_and_check();
            end
        end

        // No combinational path: a write is invisible until its edge.
        drive(1'b1, 1'b1, 1'b1, 8'h20, 6'd45);
        #1;
        check("no_comb_kp", K_p, 6'd0);
        push("wr45", 6'd45, 0, 0, 0);
        step_and_check();

        // Write then immediate read of a different register, then of the written one.
        drive(1'b1, 1'b1, 1'b1, 8'h21, 6'd1);
        push("wr_ki1", 6'd45, 6'd1, 0, 0);
        step_and_check();
        drive(1'b1, 1'b1, 1'b0, 8'h21, 6'd0);
        push("rd_ki1", 6'd45, 6'd1, 0, 6'd1);
        step_and_check();
        drive(1'b1, 1'b1, 1'b0, 8'h20, 6'd0);
        push("rd_kp45", 6'd45, 6'd1, 0, 6'd45);
        step_and_check();

        // Random phase against the behavioural model.
        m_kp = 6'd45; m_ki = 6'd1; m_kd = 0; m_rv = 6'd45;
        for (int n = 0; n < 200; n++) begin
            logic       r, e, rw;
            logic [7:0] a;
            logic [5:0] d;
            logic [7:0] pick;
            r    = ($urandom_range(0, 29) != 0);
            e    = ($urandom_range(0, 4) != 0);
            rw   = $urandom_range(0, 1);
            pick = 8'($urandom_range(0, 4));
            a    = (pick == 4) ? 8'($urandom_range(0, 255)) : 8'h20 + pick;
            d    = 6'($urandom_range(0, 63));
            drive(r, e, rw, a, d);
            model_step(r, e, rw, a, d);
            push($sformatf("rnd%0d", n), m_kp, m_ki, m_kd, m_rv);
            step_and_check();
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
